// File: rtl/insn_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : insn_decode                                                  |
// | Description : RV32 decode stage with a 32-entry register file. Accepts one |
// |               instruction per cycle through a valid/ready handshake and    |
// |               presents a single registered bundle of decoded fields and    |
// |               operand values one cycle later.                              |
// | Config macro: INSN_DECODE_BYPASS_EN                                        |
// |               defined   -> same-cycle writeback is forwarded into operands |
// |               undefined -> the decoder stalls on a writeback hazard        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module insn_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     insn,
  input  logic            wb_enable,
  input  logic [4:0]      wb_idx,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [19:0]     imm,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [4:0]      rd_idx,
  output logic            illegal,
  output logic [31:0]     decode_count
);

  localparam logic [6:0] c_OP_LUI = 7'b0110111;
  localparam logic [6:0] c_OP_REG = 7'b0110011;
  localparam logic [6:0] c_OP_IMM = 7'b0010011;

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic            out_valid_q, out_valid_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [19:0]     imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     decode_count_q, decode_count_d;

  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic            wb_hit;
  logic            rs1_match;
  logic            rs2_match;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_idx   = insn[19:15];
  assign rs2_idx   = insn[24:20];
  // x0 is never written, so a writeback to it never counts as a hit
  assign wb_hit    = wb_enable && (wb_idx != 5'd0);
  assign rs1_match = wb_hit && (wb_idx == rs1_idx);
  assign rs2_match = wb_hit && (wb_idx == rs2_idx);

`ifdef INSN_DECODE_BYPASS_EN
  // Forward the in-flight writeback instead of stalling
  assign hazard  = 1'b0;
  assign rs1_val = rs1_match ? wb_data : rf_q[rs1_idx];
  assign rs2_val = rs2_match ? wb_data : rf_q[rs2_idx];
`else
  // Hold the instruction off until the writeback has landed in the file
  assign hazard  = rs1_match || rs2_match;
  assign rs1_val = rf_q[rs1_idx];
  assign rs2_val = rf_q[rs2_idx];
`endif

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Register file next state: apply the writeback strobe, x0 excluded
  always_comb begin
    rf_d = rf_q;
    if (wb_hit) begin
      rf_d[wb_idx] = wb_data;
    end
  end

  // Output bundle next state: load on accept, drop on consume, else hold
  always_comb begin
    out_valid_d    = out_valid_q;
    opcode_d       = opcode_q;
    funct3_d       = funct3_q;
    funct7_d       = funct7_q;
    imm_d          = imm_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_idx_d       = rd_idx_q;
    illegal_d      = illegal_q;
    decode_count_d = decode_count_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      opcode_d       = insn[6:0];
      funct3_d       = insn[14:12];
      funct7_d       = insn[31:25];
      rd_idx_d       = insn[11:7];
      decode_count_d = decode_count_q + 32'd1;
      case (insn[6:0])
        c_OP_LUI: begin
          imm_d     = insn[31:12];
          illegal_d = 1'b0;
        end
        c_OP_IMM: begin
          imm_d     = {{8{insn[31]}}, insn[31:20]};
          illegal_d = 1'b0;
        end
        c_OP_REG: begin
          imm_d     = 20'd0;
          illegal_d = 1'b0;
        end
        default: begin
          imm_d     = 20'd0;
          illegal_d = 1'b1;
        end
      endcase
      // Unsupported opcodes carry no operands
      rs1_d = illegal_d ? '0 : rs1_val;
      rs2_d = illegal_d ? '0 : rs2_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset clears the file and drops any pending bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
      out_valid_q    <= 1'b0;
      opcode_q       <= '0;
      funct3_q       <= '0;
      funct7_q       <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_idx_q       <= '0;
      illegal_q      <= 1'b0;
      decode_count_q <= '0;
    end else begin
      rf_q           <= rf_d;
      out_valid_q    <= out_valid_d;
      opcode_q       <= opcode_d;
      funct3_q       <= funct3_d;
      funct7_q       <= funct7_d;
      imm_q          <= imm_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_idx_q       <= rd_idx_d;
      illegal_q      <= illegal_d;
      decode_count_q <= decode_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign opcode       = opcode_q;
  assign funct3       = funct3_q;
  assign funct7       = funct7_q;
  assign imm          = imm_q;
  assign rs1          = rs1_q;
  assign rs2          = rs2_q;
  assign rd_idx       = rd_idx_q;
  assign illegal      = illegal_q;
  assign decode_count = decode_count_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_insn_decode                                               |
// | Description : Self-checking bench for insn_decode: directed scenarios plus |
// |               randomized traffic against a behavioural reference model.    |
// |               Honors INSN_DECODE_BYPASS_EN the same way as the design.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_insn_decode;

  localparam int XLEN = 32;
  localparam int BW   = 7 + 3 + 7 + 20 + XLEN + XLEN + 5 + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     insn = '0;
  logic            wb_enable = 1'b0;
  logic [4:0]      wb_idx = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [19:0]     imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_idx;
  logic            illegal;
  logic [31:0]     decode_count;

  insn_decode #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .insn(insn), .wb_enable(wb_enable), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rd_idx(rd_idx), .illegal(illegal), .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [32];
  logic            m_known = 1'b0;
  logic            m_valid;
  logic [BW-1:0]   m_bundle;
  logic [31:0]     m_count;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decoded bundle from the instruction word and its resolved operand values
  function automatic logic [BW-1:0] model_decode(input logic [31:0] w,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [6:0]  op;
    logic        bad;
    logic [19:0] im;
    op  = w[6:0];
    bad = !(op == 7'h37 || op == 7'h33 || op == 7'h13);
    if (op == 7'h37)      im = w[31:12];
    else if (op == 7'h13) im = (w[31] ? 20'hFF000 : 20'h0) | 20'(w[31:20]);
    else                  im = 20'h0;
    return {op, w[14:12], w[31:25], im, bad ? '0 : a, bad ? '0 : b, w[11:7], bad};
  endfunction

  function automatic logic [XLEN-1:0] model_read(input logic [4:0] idx);
    if (idx == 0) return '0;
`ifdef INSN_DECODE_BYPASS_EN
    if (wb_enable && wb_idx == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  // One clock: check handshake before the edge, advance model, check after
  task automatic cycle();
    logic hz, exp_rdy, acc;
    logic [BW-1:0] nb;
    #2;
    hz = 1'b0;
`ifndef INSN_DECODE_BYPASS_EN
    hz = wb_enable && wb_idx != 0 && (wb_idx == insn[19:15] || wb_idx == insn[24:20]);
`endif
    exp_rdy = (!m_valid || out_ready) && !hz;
    if (m_known) check("in_ready", 128'(in_ready), 128'(exp_rdy));
    acc = in_valid && exp_rdy && !rst;
    nb  = model_decode(insn, model_read(insn[19:15]), model_read(insn[24:20]));
    @(posedge clk);
    #1;
    if (rst) begin
      m_known  = 1'b1;
      m_valid  = 1'b0;
      m_bundle = '0;
      m_count  = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (m_known) begin
      if (acc) begin
        m_valid  = 1'b1;
        m_bundle = nb;
        m_count  = m_count + 1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_enable && wb_idx != 0) m_regs[wb_idx] = wb_data;
    end
    if (m_known) begin
      check("out_valid", 128'(out_valid), 128'(m_valid));
      check("decode_count", 128'(decode_count), 128'(m_count));
      check("bundle", 128'({opcode, funct3, funct7, imm, rs1, rs2, rd_idx, illegal}),
            128'(m_bundle));
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] w,
                       input logic we, input logic [4:0] wi, input logic [XLEN-1:0] wd,
                       input logic ordy);
    rst = r; in_valid = v; insn = w;
    wb_enable = we; wb_idx = wi; wb_data = wd; out_ready = ordy;
    cycle();
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h33;
      2: w[6:0] = 7'h13;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;

  initial begin
    // Reset with an instruction presented: it must not be accepted
    drive(1, 1, 32'h123450B7, 1, 5'd4, 32'h55, 1);
    drive(1, 1, 32'h123450B7, 0, 0, 0, 1);
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // lui x1,0x12345
    drive(0, 1, 32'h123450B7, 0, 0, 0, 1);
    check("lui_valid", 128'(out_valid), 128'(1));
    check("lui_opcode", 128'(opcode), 128'(7'h37));
    check("lui_imm", 128'(imm), 128'(20'h12345));
    check("lui_rd", 128'(rd_idx), 128'(5'd1));
    check("lui_illegal", 128'(illegal), 128'(0));
    check("lui_count", 128'(decode_count), 128'(1));

    // wb x1=5, x2=7, then add x3,x1,x2
    drive(0, 0, 0, 1, 5'd1, 32'd5, 1);
    drive(0, 0, 0, 1, 5'd2, 32'd7, 1);
    drive(0, 1, ADD_X3_X1_X2, 0, 0, 0, 1);
    check("add_rs1", 128'(rs1), 128'(5));
    check("add_rs2", 128'(rs2), 128'(7));
    check("add_funct", 128'({funct7, funct3}), 128'(0));
    check("add_rd", 128'(rd_idx), 128'(3));

    // Same-cycle writeback to x1 while presenting add x3,x1,x2
    drive(0, 1, ADD_X3_X1_X2, 1, 5'd1, 32'hA, 1);
`ifdef INSN_DECODE_BYPASS_EN
    check("byp_valid", 128'(out_valid), 128'(1));
    check("byp_rs1", 128'(rs1), 128'(32'hA));
`else
    check("stall_valid", 128'(out_valid), 128'(0));
    drive(0, 1, ADD_X3_X1_X2, 0, 0, 0, 1);
    check("stall_rs1", 128'(rs1), 128'(32'hA));
`endif

    // Backpressure: first bundle held 3 cycles with a second one pending
    drive(0, 1, 32'h000052B7, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'hFFF08193, 0, 0, 0, 0);
      check("hold_opcode", 128'(opcode), 128'(7'h37));
      check("hold_ready", 128'(in_ready), 128'(0));
    end
    drive(0, 1, 32'hFFF08193, 0, 0, 0, 1);
    check("nobubble_valid", 128'(out_valid), 128'(1));
    check("nobubble_imm", 128'(imm), 128'(20'hFFFFF));
    check("nobubble_rs1", 128'(rs1), 128'(32'hA));

    // Illegal opcodes carry zero operands
    drive(0, 1, 32'h0000006F, 0, 0, 0, 1);
    check("jal_illegal", 128'(illegal), 128'(1));
    drive(0, 1, 32'h00208063, 0, 0, 0, 1);
    check("beq_illegal", 128'(illegal), 128'(1));
    check("beq_rs", 128'({rs1, rs2}), 128'(0));

    // Writes to x0 are discarded
    drive(0, 0, 0, 1, 5'd0, 32'hFF, 1);
    drive(0, 1, 32'h000001B3, 0, 0, 0, 1);
    check("x0_rs1", 128'(rs1), 128'(0));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), rand_insn(),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) != 0));
    end

    // Reset with a pending bundle drops it and clears the register file
    drive(0, 0, 0, 1, 5'd1, 32'h1234, 1);
    drive(0, 1, 32'h00100093, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_count", 128'(decode_count), 128'(0));
    check("rst_fields", 128'({opcode, funct3, funct7, imm, rs1, rs2, rd_idx, illegal}), 128'(0));
    drive(0, 1, ADD_X3_X1_X2, 0, 0, 0, 1);
    check("rst_rf_rs1", 128'(rs1), 128'(0));
    check("rst_rf_count", 128'(decode_count), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
